uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
// - Shares one UART transmitter among NUM_REQ byte producers (CPU store path, debug dumper, etc.) using round-robin arbitration.
// - Latches the granted byte and issues a one-cycle start strobe to the transmitter.
// - Tracks the transmitter free flag through busy and back to free before the next grant.
// - Sits between the requesters and the UART send path; runs entirely in the clk_50m domain.
// PARAMETERS
// - NUM_REQ        4    number of requesters (2..8)
// - GID_W          2    width of grant_id; must be >= clog2(NUM_REQ)
// - BUSY_TIMEOUT   64   clk_50m cycles to wait for tx_free to drop after tx_start
// PORTS
// - clk_50m      in   1            system clock, 50 MHz
// - reset_b      in   1            asynchronous active-low reset
// - enable       in   1            when low, no new grants; an in-flight byte completes
// - req          in   NUM_REQ      level request per requester; held until ack
// - req_data     in   8*NUM_REQ    byte of requester i at [8*i+7:8*i]; stable while req[i]
// - req_ack      out  NUM_REQ      one-hot, one-cycle pulse: byte of requester i accepted
// - tx_free      in   1            transmitter idle flag (high = can accept a byte)
// - tx_start     out  1            one-cycle strobe to the transmitter
// - tx_data      out  8            byte to transmit; held stable from tx_start to return to IDLE
// - grant_id     out  GID_W        index of the last granted requester
// - busy         out  1            high in every state except IDLE
// - timeout_err  out  1            one-cycle pulse when BUSY_TIMEOUT expires
// BEHAVIOUR
// - Reset state: FSM=IDLE, rr_ptr=0.
// - Reset output values: tx_start=0, tx_data=0, req_ack=0, grant_id=0, busy=0, timeout_err=0.
// - Reset is asynchronous at any time and aborts any transfer; no ack or strobe is emitted afterwards.
// - FSM states: IDLE -> LOAD -> WAIT_BUSY -> WAIT_FREE -> IDLE.
// - IDLE: requires enable & tx_free & |req to grant.
//   - Winner is the first set req[k] scanning k = rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
//   - On grant: latch tx_data <= req_data[k]; grant_id <= k; pulse req_ack[k]; rr_ptr <= (k+1) mod NUM_REQ; go to LOAD.
//   - A requester may drop req the cycle after its ack. If req is still high, it is treated as a new byte.
// - LOAD: tx_start=1 for exactly this cycle; clear timeout counter; go to WAIT_BUSY.
//   - Grant-to-strobe latency is 1 cycle.
// - WAIT_BUSY: waits for tx_free=0, which the baud-domain sender may take several cycles to show.
//   - tx_free=0 -> WAIT_FREE.
//   - Otherwise the counter increments. When it reaches BUSY_TIMEOUT-1: pulse timeout_err and go to IDLE.
//   - The timed-out byte is dropped and has already been acked; rr_ptr is not rewound.
// - WAIT_FREE: tx_free=1 -> IDLE. There is no timeout in this state.
//   - The minimum gap between consecutive tx_start pulses is 4 cycles.
// - Arbitration edge cases:
//   - Simultaneous requests: exactly one ack per grant.
//   - Any requester waits at most NUM_REQ-1 grants.
//   - A request for rr_ptr itself wins ties.
//   - Wrap-around: pointer after NUM_REQ-1 is 0.
// - enable falling mid-transfer has no effect until IDLE. req changes outside IDLE are ignored.
// - req_ack is never asserted in the same cycle as tx_start.
// - Ack, tx_start and timeout_err are all single-cycle pulses, never stretched.
// TESTING
// - Reset mid-WAIT_FREE with req=4'b0001:
//   - all outputs 0 immediately;
//   - after release with tx_free=1, a grant to requester 0 in the first IDLE cycle.
// - Single request: req=4'b0100, req_data[23:16]=8'hA5, tx_free=1:
//   - req_ack=4'b0100 in cycle N;
//   - tx_start=1 and tx_data=8'hA5 in cycle N+1.
// - Fairness: req=4'b1111 held, each byte distinct, transmitter model busy for 10 cycles:
//   - grant order 0,1,2,3,0;
//   - no tx_start while tx_free=0.
// - Wrap: rr_ptr=3, req=4'b1001:
//   - grant 3, then 0;
//   - rr_ptr returns to 0, then to 1.
// - Timeout: tx_free stuck at 1 after tx_start:
//   - timeout_err pulses exactly BUSY_TIMEOUT cycles after tx_start;
//   - FSM returns to IDLE and the next requester is granted.
// - enable=0 with pending req:
//   - no ack and busy=0;
//   - raising enable grants on the next cycle.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte producers.
// Grants one byte at a time, strobes the transmitter and follows tx_free busy/free.
module uart_tx_scheduler #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned GID_W        = 2,
  parameter int unsigned BUSY_TIMEOUT = 64
) (
  input  logic                 clk_50m,
  input  logic                 reset_b,
  input  logic                 enable,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ack,
  input  logic                 tx_free,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  output logic [GID_W-1:0]     grant_id,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(BUSY_TIMEOUT - 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StWaitBusy,
    StWaitFree
  } state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [GID_W-1:0]  grant_id_q, grant_id_d;

  logic [7:0]        req_bytes [NUM_REQ];
  logic [PtrW-1:0]   winner;
  logic [PtrW-1:0]   scan_idx;
  logic [31:0]       scan_sum;
  logic              found;
  logic              grant;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign req_bytes[g] = req_data[8*g +: 8];
  end

  // First set request scanning upward from rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    scan_idx = '0;
    scan_sum = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_sum = 32'(rr_ptr_q) + i;
      if (scan_sum >= NUM_REQ) begin
        scan_sum = scan_sum - NUM_REQ;
      end
      scan_idx = PtrW'(scan_sum);
      if (!found && req[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  assign grant = (state_q == StIdle) && enable && tx_free && found;

  // Ack is decoded from the idle state, so it is masked while reset is held.
  always_comb begin
    req_ack = '0;
    if (grant && reset_b) begin
      req_ack = NUM_REQ'(1) << winner;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    tx_data_d   = tx_data_q;
    grant_id_d  = grant_id_q;
    tx_start    = 1'b0;
    timeout_err = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          tx_data_d  = req_bytes[winner];
          grant_id_d = GID_W'(winner);
          rr_ptr_d   = (winner == PtrLast) ? '0 : winner + 1'b1;
          state_d    = StLoad;
        end
      end
      StLoad: begin
        tx_start = 1'b1;
        cnt_d    = '0;
        state_d  = StWaitBusy;
      end
      StWaitBusy: begin
        if (!tx_free) begin
          state_d = StWaitFree;
        end else if (cnt_q == CntLast) begin
          // Byte is dropped; it was already acked and the pointer stays advanced.
          timeout_err = 1'b1;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitFree: begin
        if (tx_free) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_50m or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign grant_id = grant_id_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: requester and transmitter models drive the DUT,
// expected grants are queued by the stimulus and checked by an independent monitor.
module tb_uart_tx_scheduler;
  localparam int NumReq      = 4;
  localparam int GidW        = 2;
  localparam int BusyTimeout = 64;

  logic                clk_50m = 1'b0;
  logic                reset_b = 1'b0;
  logic                enable  = 1'b0;
  logic                tx_free = 1'b1;
  logic [NumReq-1:0]   req;
  logic [8*NumReq-1:0] req_data;
  logic [NumReq-1:0]   req_ack;
  logic                tx_start;
  logic [7:0]          tx_data;
  logic [GidW-1:0]     grant_id;
  logic                busy;
  logic                timeout_err;

  uart_tx_scheduler #(
    .NUM_REQ      (NumReq),
    .GID_W        (GidW),
    .BUSY_TIMEOUT (BusyTimeout)
  ) dut (
    .clk_50m     (clk_50m),
    .reset_b     (reset_b),
    .enable      (enable),
    .req         (req),
    .req_data    (req_data),
    .req_ack     (req_ack),
    .tx_free     (tx_free),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #10 clk_50m = ~clk_50m;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  exp_t        pend;
  bit          pend_valid = 1'b0;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          exp_to = 0;
  int          ack_cyc = 0;
  int          start_cyc = -1000;
  int          bytes_left [NumReq];
  logic [7:0]  byte_val [NumReq];
  logic [3:0]  ack_pend = '0;
  bit          tx_stuck = 1'b0;
  bit          model_busy = 1'b0;

  for (genvar g = 0; g < NumReq; g++) begin : g_req
    assign req[g]            = (bytes_left[g] != 0);
    assign req_data[8*g +: 8] = byte_val[g];
  end

  always @(posedge clk_50m) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic push(input logic [1:0] idx, input logic [7:0] data);
    exp_t e;
    e.idx  = idx;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || pend_valid || busy || model_busy || ack_pend != 0 ||
            exp_to != 0) && n < 400) begin
      @(negedge clk_50m);
      n++;
    end
    check(name, 32'(n < 400), 1);
    @(posedge clk_50m);
    #1;
  endtask

  // Monitor: pops expected grants on ack, checks the strobe that follows, and timeouts.
  initial forever begin
    @(negedge clk_50m);
    if (!reset_b) pend_valid = 1'b0;
    if (req_ack != 0) begin
      check("ack_with_start", 32'(tx_start), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 32'(req_ack), 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("ack_onehot", 32'(req_ack), 32'(1) << mon_e.idx);
        pend       = mon_e;
        pend_valid = 1'b1;
        ack_cyc    = cyc;
      end
      for (int i = 0; i < NumReq; i++) begin
        if (req_ack[i]) ack_pend[i] = 1'b1;
      end
    end
    if (tx_start) begin
      check("start_pending", 32'(pend_valid), 1);
      check("start_latency", cyc - ack_cyc, 1);
      check("tx_data", 32'(tx_data), 32'(pend.data));
      check("grant_id", 32'(grant_id), 32'(pend.idx));
      check("start_while_tx_busy", 32'(tx_free), 1);
      pend_valid = 1'b0;
      start_cyc  = cyc;
    end
    if (timeout_err) begin
      check("timeout_expected", 32'(exp_to > 0), 1);
      check("timeout_delay", cyc - start_cyc, BusyTimeout);
      if (exp_to > 0) exp_to--;
    end
  end

  // Requesters: retire the acked byte and present the next one after the grant edge.
  initial forever begin
    @(posedge clk_50m);
    #1;
    for (int i = 0; i < NumReq; i++) begin
      if (ack_pend[i]) begin
        ack_pend[i] = 1'b0;
        if (bytes_left[i] > 0) bytes_left[i]--;
        byte_val[i] = byte_val[i] + 8'd1;
      end
    end
  end

  // Transmitter: tx_free drops 2 cycles after the strobe and stays low for 10 cycles.
  initial forever begin
    @(negedge clk_50m);
    if (tx_start && !tx_stuck) begin
      model_busy = 1'b1;
      repeat (2) @(posedge clk_50m);
      #1 tx_free = 1'b0;
      repeat (10) @(posedge clk_50m);
      #1 tx_free = 1'b1;
      model_busy = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running want done");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < NumReq; i++) begin
      bytes_left[i] = 0;
      byte_val[i]   = 8'h00;
    end
    enable = 1'b1;
    repeat (2) @(negedge clk_50m);
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_req_ack", 32'(req_ack), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_timeout_err", 32'(timeout_err), 0);
    @(posedge clk_50m);
    #1 reset_b = 1'b1;
    @(posedge clk_50m);
    #1;

    // Fairness from rr_ptr=0 with all four requesting.
    byte_val[0] = 8'h10; byte_val[1] = 8'h20; byte_val[2] = 8'h30; byte_val[3] = 8'h40;
    bytes_left[0] = 2; bytes_left[1] = 1; bytes_left[2] = 1; bytes_left[3] = 1;
    push(2'd0, 8'h10); push(2'd1, 8'h20); push(2'd2, 8'h30); push(2'd3, 8'h40);
    push(2'd0, 8'h11);
    wait_idle("fair_done");

    // Single request, rr_ptr=1.
    byte_val[2] = 8'hA5; bytes_left[2] = 1;
    push(2'd2, 8'hA5);
    wait_idle("single_done");

    // Wrap: rr_ptr=3, req=1001.
    byte_val[3] = 8'h3C; byte_val[0] = 8'hC3;
    bytes_left[3] = 1; bytes_left[0] = 1;
    push(2'd3, 8'h3C); push(2'd0, 8'hC3);
    wait_idle("wrap_done");

    // Pointer now at 1: req=0011 grants 1 before 0.
    byte_val[0] = 8'h5A; byte_val[1] = 8'h96;
    bytes_left[0] = 1; bytes_left[1] = 1;
    push(2'd1, 8'h96); push(2'd0, 8'h5A);
    wait_idle("ptr_done");

    // Timeout: transmitter never goes busy.
    tx_stuck = 1'b1;
    byte_val[1] = 8'h71; byte_val[2] = 8'h72;
    bytes_left[1] = 1; bytes_left[2] = 1;
    exp_to = 2;
    push(2'd1, 8'h71); push(2'd2, 8'h72);
    wait_idle("timeout_done");
    check("timeouts_seen", exp_to, 0);
    tx_stuck = 1'b0;

    // enable low holds off a pending request.
    enable = 1'b0;
    byte_val[3] = 8'hE7; bytes_left[3] = 1;
    repeat (4) begin
      @(negedge clk_50m);
      check("dis_no_ack", 32'(req_ack), 0);
      check("dis_busy", 32'(busy), 0);
    end
    push(2'd3, 8'hE7);
    @(posedge clk_50m);
    #1 enable = 1'b1;
    @(negedge clk_50m);
    check("en_ack", 32'(req_ack), 32'b1000);
    wait_idle("enable_done");

    // Reset in WAIT_FREE, then a fresh grant to requester 0.
    byte_val[0] = 8'h81; bytes_left[0] = 2;
    push(2'd0, 8'h81);
    n = 0;
    while (tx_free && n < 50) begin
      @(negedge clk_50m);
      n++;
    end
    check("reach_tx_busy", 32'(tx_free), 0);
    repeat (2) @(posedge clk_50m);
    #1 reset_b = 1'b0;
    #1;
    check("arst_tx_start", 32'(tx_start), 0);
    check("arst_tx_data", 32'(tx_data), 0);
    check("arst_req_ack", 32'(req_ack), 0);
    check("arst_grant_id", 32'(grant_id), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_timeout_err", 32'(timeout_err), 0);
    n = 0;
    while (!tx_free && n < 50) begin
      @(negedge clk_50m);
      n++;
    end
    check("tx_free_back", 32'(tx_free), 1);
    @(posedge clk_50m);
    #1;
    push(2'd0, 8'h82);
    reset_b = 1'b1;
    @(negedge clk_50m);
    check("post_rst_ack", 32'(req_ack), 32'b0001);
    wait_idle("reset_done");

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
